pe_sequencer: RTL

- Control-side initiator for the bit-serial processing-element array; it produces the per-cycle instruction fields each PE consumes: w, ra, rb, src, op, imm, re.
- Holds a small loadable program store and runs it from address 0 on a start pulse.
- Drives one instruction per cycle, supports one level of counted looping, and signals completion with a done pulse.
- Its outputs fan out unchanged to every PE in the array.

---
 rtl/pe_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pe_sequencer.sv
// Purpose : program-store sequencer that issues per-cycle instruction fields to the PE array.
// Latency : first instruction registered one cycle after start is accepted; then one per cycle.
// Backpr. : none; outputs advance every cycle while running, start is ignored unless idle.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   prog_we, prog_addr, prog_wdata   program-store write port (only honoured while idle)
//   start                            run request, sampled in IDLE
//   busy, done, issue_valid          run status, HALT-retire pulse, ISSUE qualifier
//   pe_w/ra/rb/src/op/imm/re         instruction fields broadcast to every PE
module pe_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int LOOP_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [19:0] prog_wdata,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        issue_valid,
    output logic [2:0]  pe_w,
    output logic [2:0]  pe_ra,
    output logic [2:0]  pe_rb,
    output logic [2:0]  pe_src,
    output logic [2:0]  pe_op,
    output logic        pe_imm,
    output logic        pe_re
);

    localparam logic [1:0] K_ISSUE = 2'b00;
    localparam logic [1:0] K_NOP   = 2'b01;
    localparam logic [1:0] K_LOOP  = 2'b10;
    localparam logic [1:0] K_HALT  = 2'b11;

    // src=7 selects the constant-0 input so an idle cycle can never write a register.
    localparam logic [2:0] SRC_IDLE = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    logic [19:0]       prog_mem [PROG_DEPTH];
    state_t            state, state_nxt;
    logic [3:0]        pc, pc_nxt;
    logic              loop_active, loop_active_nxt;
    logic [LOOP_W-1:0] loop_cnt, loop_cnt_nxt;

    logic [19:0]       instr;
    logic [1:0]        kind;
    logic [3:0]        loop_target;
    logic [LOOP_W-1:0] loop_count;
    logic              unused_bits;

    logic              busy_nxt, done_nxt, issue_valid_nxt;
    logic [2:0]        w_nxt, ra_nxt, rb_nxt, src_nxt, op_nxt;
    logic              imm_nxt, re_nxt;

    assign instr       = prog_mem[pc];
    assign kind        = instr[19:18];
    assign loop_target = instr[11:8];
    assign loop_count  = instr[LOOP_W-1:0];
    assign unused_bits = instr[0];

    // Program store: not reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (!rst && prog_we && state == IDLE) begin
            prog_mem[prog_addr] <= prog_wdata;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= 4'd0;
            loop_active <= 1'b0;
            loop_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            issue_valid <= 1'b0;
            pe_w        <= 3'd0;
            pe_ra       <= 3'd0;
            pe_rb       <= 3'd0;
            pe_src      <= SRC_IDLE;
            pe_op       <= 3'd0;
            pe_imm      <= 1'b0;
            pe_re       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            loop_active <= loop_active_nxt;
            loop_cnt    <= loop_cnt_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            issue_valid <= issue_valid_nxt;
            pe_w        <= w_nxt;
            pe_ra       <= ra_nxt;
            pe_rb       <= rb_nxt;
            pe_src      <= src_nxt;
            pe_op       <= op_nxt;
            pe_imm      <= imm_nxt;
            pe_re       <= re_nxt;
        end
    end

    // Next-state: pc sequencing and the single-level loop counter.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        loop_active_nxt = loop_active;
        loop_cnt_nxt    = loop_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = 4'd0;
                end
            end
            RUN: begin
                case (kind)
                    K_ISSUE, K_NOP: pc_nxt = pc + 4'd1;
                    K_LOOP: begin
                        // A LOOP seen while a loop is live uses the live counter,
                        // so the body runs count+1 times in total.
                        if (!loop_active) begin
                            if (loop_count == '0) begin
                                pc_nxt = pc + 4'd1;
                            end else begin
                                loop_cnt_nxt    = loop_count - 1'b1;
                                loop_active_nxt = 1'b1;
                                pc_nxt          = loop_target;
                            end
                        end else if (loop_cnt == '0) begin
                            loop_active_nxt = 1'b0;
                            pc_nxt          = pc + 4'd1;
                        end else begin
                            loop_cnt_nxt = loop_cnt - 1'b1;
                            pc_nxt       = loop_target;
                        end
                    end
                    K_HALT: begin
                        state_nxt       = IDLE;
                        loop_active_nxt = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the next cycle; idle encoding unless an ISSUE retires.
    always_comb begin
        busy_nxt        = (state_nxt == RUN);
        done_nxt        = (state == RUN) && (kind == K_HALT);
        issue_valid_nxt = 1'b0;
        w_nxt           = 3'd0;
        ra_nxt          = 3'd0;
        rb_nxt          = 3'd0;
        src_nxt         = SRC_IDLE;
        op_nxt          = 3'd0;
        imm_nxt         = 1'b0;
        re_nxt          = 1'b0;
        if (state == RUN && kind == K_ISSUE) begin
            issue_valid_nxt = 1'b1;
            w_nxt           = instr[17:15];
            ra_nxt          = instr[14:12];
            rb_nxt          = instr[11:9];
            src_nxt         = instr[8:6];
            op_nxt          = instr[5:3];
            imm_nxt         = instr[2];
            re_nxt          = instr[1];
        end
    end

endmodule
